// File: rtl/hyper_resp_pkg.sv
// Shared types, constants and address-advance helper for the HyperBus memory responder.
package hyper_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    RD,
    WR,
    REGWR
  } state_e;

  // Command/address word as it arrives on DQ, MSB byte first.
  typedef struct packed {
    logic        rw;
    logic        as;
    logic        burst;
    logic [28:0] row;
    logic [12:0] rsvd;
    logic [2:0]  col;
  } ca_t;

  localparam int unsigned CaBytes = 6;
  localparam int unsigned CaBits  = 8 * CaBytes;

  // Linear bursts count straight up; wrapped bursts only move the bits under wrap_mask.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic linear,
                                            input logic [31:0] wrap_mask);
    logic [31:0] inc;
    inc = addr + 32'd1;
    if (linear) begin
      next_addr = inc;
    end else begin
      next_addr = (addr & ~wrap_mask) | (inc & wrap_mask);
    end
  endfunction

endpackage

// File: rtl/hyper_resp_edge_sync.sv
// Two-flop synchronizers for all HyperBus inputs (equal depth keeps them aligned)
// plus rise/fall pulses of the synchronized CK.
module hyper_resp_edge_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ck_i,
  input  logic       cs_ni,
  input  logic       hrst_ni,
  input  logic [7:0] dq_i,
  input  logic       rwds_i,
  output logic       cs_n_o,
  output logic       hrst_n_o,
  output logic [7:0] dq_o,
  output logic       rwds_o,
  output logic       rise_c,
  output logic       fall_c
);

  localparam int unsigned SyncW = 12;
  // Reset to an idle bus: CK low, CS# deasserted, device reset asserted.
  localparam logic [SyncW-1:0] SyncRst = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

  logic [SyncW-1:0] meta_d, meta_q;
  logic [SyncW-1:0] sync_d, sync_q;
  logic             ck_prev_d, ck_prev_q;
  logic             ck_s;

  always_comb begin
    meta_d    = {ck_i, cs_ni, hrst_ni, rwds_i, dq_i};
    sync_d    = meta_q;
    ck_prev_d = sync_q[SyncW-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q    <= SyncRst;
      sync_q    <= SyncRst;
      ck_prev_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      ck_prev_q <= ck_prev_d;
    end
  end

  assign {ck_s, cs_n_o, hrst_n_o, rwds_o, dq_o} = sync_q;
  assign rise_c = ck_s & ~ck_prev_q;
  assign fall_c = ~ck_s & ck_prev_q;

endmodule

// File: rtl/hyper_resp_mem.sv
// HyperBus memory responder serving CA/latency/data bursts from an internal word array.
// Optional protocol checker driving err_o: define HYPER_RESP_PROTO_CHECK_EN.
module hyper_resp_mem
  import hyper_resp_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned LatCycles = 6,
  parameter int unsigned WrapWords = 16,
  parameter logic [15:0] IdValue   = 16'h0c81
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hyper_ck_i,
  input  logic       hyper_cs_ni,
  input  logic       hyper_rst_ni,
  input  logic [7:0] dq_i,
  output logic [7:0] dq_o,
  output logic       dq_oe_o,
  input  logic       rwds_i,
  output logic       rwds_o,
  output logic       rwds_oe_o,
  output logic       err_o
);

  localparam int unsigned AddrW    = $clog2(NumWords);
  localparam int unsigned LatW     = $clog2(2 * LatCycles);
  localparam int unsigned CntW     = 3;
  localparam int unsigned CaShiftW = CaBits - 8;
  localparam logic [LatW-1:0] LatInit  = LatW'(2 * LatCycles - 1);
  localparam logic [31:0]     WrapMask = 32'(WrapWords - 1);

  logic       cs_n_s, hrst_n_s, rwds_s, rise, fall;
  logic [7:0] dq_s;

  hyper_resp_edge_sync u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .ck_i    (hyper_ck_i),
    .cs_ni   (hyper_cs_ni),
    .hrst_ni (hyper_rst_ni),
    .dq_i    (dq_i),
    .rwds_i  (rwds_i),
    .cs_n_o  (cs_n_s),
    .hrst_n_o(hrst_n_s),
    .dq_o    (dq_s),
    .rwds_o  (rwds_s),
    .rise_c  (rise),
    .fall_c  (fall)
  );

  state_e              state_d, state_q;
  logic [CaShiftW-1:0] ca_d, ca_q;
  logic [CntW-1:0]     ca_cnt_d, ca_cnt_q;
  logic [LatW-1:0]     lat_d, lat_q;
  logic [AddrW-1:0]    addr_d, addr_q;
  logic                linear_d, linear_q;
  logic                reg_d, reg_q;
  logic                rw_d, rw_q;
  logic                armed_d, armed_q;
  logic                hi_vld_d, hi_vld_q;
  logic [7:0]          hi_byte_d, hi_byte_q;
  logic                hi_msk_d, hi_msk_q;
  logic [7:0]          dq_d, dq_q;
  logic                dq_oe_d, dq_oe_q;
  logic                rwds_d, rwds_q;
  logic                rwds_oe_d, rwds_oe_q;

  logic [15:0]      mem_q [NumWords];
  logic [1:0]       mem_we_c;
  logic [15:0]      rd_word;
  logic [AddrW-1:0] addr_adv;
  ca_t              ca_full;
  logic             ca_unused;

  assign ca_full   = ca_t'({ca_q, dq_s});
  assign ca_unused = ^ca_full;
  assign rd_word   = reg_q ? IdValue : mem_q[addr_q];
  assign addr_adv  = AddrW'(next_addr(32'(addr_q), linear_q, WrapMask));

  // Next-state and output logic; a deasserted CS# or device reset overrides any CK edge.
  always_comb begin
    state_d   = state_q;
    ca_d      = ca_q;
    ca_cnt_d  = ca_cnt_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    linear_d  = linear_q;
    reg_d     = reg_q;
    rw_d      = rw_q;
    armed_d   = armed_q | cs_n_s;
    hi_vld_d  = hi_vld_q;
    hi_byte_d = hi_byte_q;
    hi_msk_d  = hi_msk_q;
    dq_d      = dq_q;
    dq_oe_d   = dq_oe_q;
    rwds_d    = rwds_q;
    rwds_oe_d = rwds_oe_q;
    mem_we_c  = 2'b00;

    if (!hrst_n_s || cs_n_s) begin
      state_d   = IDLE;
      hi_vld_d  = 1'b0;
      dq_d      = 8'h00;
      dq_oe_d   = 1'b0;
      rwds_d    = 1'b0;
      rwds_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // armed_q blocks a second transaction until CS# has been released.
          if (armed_q) begin
            state_d   = CA;
            armed_d   = 1'b0;
            ca_cnt_d  = '0;
            rwds_oe_d = 1'b1;
            rwds_d    = 1'b1;
          end
        end
        CA: begin
          if (rise || (fall && ca_cnt_q != '0)) begin
            ca_d     = {ca_q[CaShiftW-9:0], dq_s};
            ca_cnt_d = ca_cnt_q + CntW'(1);
            if (ca_cnt_q == CntW'(CaBytes - 1)) begin
              rwds_oe_d = 1'b0;
              rwds_d    = 1'b0;
              hi_vld_d  = 1'b0;
              addr_d    = AddrW'({ca_full.row, ca_full.col});
              linear_d  = ca_full.burst;
              reg_d     = ca_full.as;
              rw_d      = ca_full.rw;
              if (!ca_full.rw && ca_full.as) begin
                state_d = REGWR;
              end else begin
                state_d = LAT;
                lat_d   = LatInit;
              end
            end
          end
        end
        LAT: begin
          if (rise) begin
            if (lat_q == '0) begin
              if (rw_q) begin
                state_d   = RD;
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
                rwds_d    = 1'b0;
              end else begin
                state_d = WR;
              end
            end else begin
              lat_d = lat_q - LatW'(1);
            end
          end
        end
        RD: begin
          if (rise) begin
            dq_d     = rd_word[15:8];
            rwds_d   = 1'b1;
            hi_vld_d = 1'b1;
          end else if (fall && hi_vld_q) begin
            dq_d     = rd_word[7:0];
            rwds_d   = 1'b0;
            hi_vld_d = 1'b0;
            addr_d   = addr_adv;
          end
        end
        WR: begin
          if (rise) begin
            hi_byte_d = dq_s;
            hi_msk_d  = rwds_s;
            hi_vld_d  = 1'b1;
          end else if (fall && hi_vld_q) begin
            mem_we_c = {~hi_msk_q, ~rwds_s};
            hi_vld_d = 1'b0;
            addr_d   = addr_adv;
          end
        end
        REGWR: begin
          if (rise) begin
            hi_vld_d = 1'b1;
          end else if (fall && hi_vld_q) begin
            hi_vld_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ca_q      <= '0;
      ca_cnt_q  <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
      linear_q  <= 1'b0;
      reg_q     <= 1'b0;
      rw_q      <= 1'b0;
      armed_q   <= 1'b0;
      hi_vld_q  <= 1'b0;
      hi_byte_q <= 8'h00;
      hi_msk_q  <= 1'b0;
      dq_q      <= 8'h00;
      dq_oe_q   <= 1'b0;
      rwds_q    <= 1'b0;
      rwds_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ca_q      <= ca_d;
      ca_cnt_q  <= ca_cnt_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      linear_q  <= linear_d;
      reg_q     <= reg_d;
      rw_q      <= rw_d;
      armed_q   <= armed_d;
      hi_vld_q  <= hi_vld_d;
      hi_byte_q <= hi_byte_d;
      hi_msk_q  <= hi_msk_d;
      dq_q      <= dq_d;
      dq_oe_q   <= dq_oe_d;
      rwds_q    <= rwds_d;
      rwds_oe_q <= rwds_oe_d;
    end
  end

  // Word array has no reset; byte lanes commit on the CK fall of each write word.
  always_ff @(posedge clk_i) begin
    if (mem_we_c[1]) mem_q[addr_q][15:8] <= hi_byte_q;
    if (mem_we_c[0]) mem_q[addr_q][7:0]  <= dq_s;
  end

`ifdef HYPER_RESP_PROTO_CHECK_EN
  logic err_d, err_q;

  // Sticky: CS# released before data phase, or CK toggling while deselected.
  always_comb begin
    err_d = err_q;
    if (cs_n_s && (state_q == CA || state_q == LAT || rise || fall)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign dq_o      = dq_q;
  assign dq_oe_o   = dq_oe_q;
  assign rwds_o    = rwds_q;
  assign rwds_oe_o = rwds_oe_q;

endmodule

// File: tb/tb_hyper_resp_mem.sv
// Self-checking bench for hyper_resp_mem: directed scenarios plus randomized bursts
// checked against a word-level memory model.
module tb_hyper_resp_mem;

  localparam int unsigned NumWords  = 1024;
  localparam int unsigned LatCycles = 6;
  localparam int unsigned WrapWords = 16;
  localparam logic [15:0] IdValue   = 16'h0c81;
`ifdef HYPER_RESP_PROTO_CHECK_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ck = 1'b0;
  logic       cs_n = 1'b1;
  logic       hrst_n = 1'b1;
  logic [7:0] dq_in = 8'h00;
  logic       rwds_in = 1'b0;
  logic [7:0] dq_out;
  logic       dq_oe, rwds_out, rwds_oe, err;

  int checks = 0;
  int errors = 0;

  bit [15:0]   mdl   [NumWords];
  bit [1:0]    known [NumWords];
  logic [15:0] wr_data [$];
  logic [1:0]  wr_msk  [$];
  logic [15:0] rd_q    [$];
  logic [1:0]  rwp_q   [$];

  hyper_resp_mem dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .hyper_ck_i  (ck),
    .hyper_cs_ni (cs_n),
    .hyper_rst_ni(hrst_n),
    .dq_i        (dq_in),
    .dq_o        (dq_out),
    .dq_oe_o     (dq_oe),
    .rwds_i      (rwds_in),
    .rwds_o      (rwds_out),
    .rwds_oe_o   (rwds_oe),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ca_addr(input logic [47:0] ca);
    logic [31:0] w;
    w = {ca[44:16], ca[2:0]};
    return int'(w % NumWords);
  endfunction

  function automatic int model_next(input int a, input logic lin);
    if (lin) return (a + 1) % NumWords;
    return (a - a % WrapWords) + ((a % WrapWords) + 1) % WrapWords;
  endfunction

  function automatic logic [47:0] make_ca(input logic rw, input logic as, input logic lin,
                                          input int a);
    logic [47:0] c;
    c        = '0;
    c[47]    = rw;
    c[46]    = as;
    c[45]    = lin;
    c[44:16] = 29'(a / 8);
    c[2:0]   = 3'(a % 8);
    return c;
  endfunction

  // ---------------- bus driving ----------------
  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ck_cycle(input logic [7:0] hi, input logic [7:0] lo, input logic mh,
                          input logic ml);
    dq_in = hi; rwds_in = mh; clk_wait(3);
    ck = 1'b1;                clk_wait(3);
    dq_in = lo; rwds_in = ml; clk_wait(3);
    ck = 1'b0;                clk_wait(3);
  endtask

  task automatic rd_cycle(output logic [15:0] w, output logic [1:0] r);
    dq_in = 8'h00;
    ck = 1'b1; clk_wait(5); w[15:8] = dq_out; r[1] = rwds_out; clk_wait(1);
    ck = 1'b0; clk_wait(5); w[7:0]  = dq_out; r[0] = rwds_out; clk_wait(1);
  endtask

  task automatic open_cs();
    cs_n = 1'b0; clk_wait(4);
  endtask

  task automatic send_ca(input logic [47:0] ca);
    for (int i = 0; i < 3; i++) ck_cycle(ca[47-16*i -: 8], ca[39-16*i -: 8], 1'b0, 1'b0);
  endtask

  task automatic lat_phase();
    repeat (2 * LatCycles) ck_cycle(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic end_xfer();
    dq_in = 8'h00; rwds_in = 1'b0; cs_n = 1'b1; clk_wait(8);
  endtask

  task automatic push_w(input logic [15:0] d, input logic [1:0] m);
    wr_data.push_back(d); wr_msk.push_back(m);
  endtask

  // Drives a full write burst from wr_data/wr_msk and applies it to the model.
  task automatic do_write(input logic [47:0] ca);
    int a;
    a = ca_addr(ca);
    open_cs(); send_ca(ca); lat_phase();
    foreach (wr_data[i]) begin
      ck_cycle(wr_data[i][15:8], wr_data[i][7:0], wr_msk[i][1], wr_msk[i][0]);
      if (!wr_msk[i][1]) begin mdl[a][15:8] = wr_data[i][15:8]; known[a][1] = 1'b1; end
      if (!wr_msk[i][0]) begin mdl[a][7:0]  = wr_data[i][7:0];  known[a][0] = 1'b1; end
      a = model_next(a, ca[45]);
    end
    end_xfer();
    wr_data.delete(); wr_msk.delete();
  endtask

  task automatic do_read(input logic [47:0] ca, input int n);
    logic [15:0] w;
    logic [1:0]  r;
    rd_q.delete(); rwp_q.delete();
    open_cs(); send_ca(ca); lat_phase();
    for (int i = 0; i < n; i++) begin
      rd_cycle(w, r); rd_q.push_back(w); rwp_q.push_back(r);
    end
    end_xfer();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; clk_wait(3);
    checks++; if (dq_out !== 8'h00) begin errors++; $display("FAIL rst_dq got %h exp 00", dq_out); end
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL rst_dq_oe got %b exp 0", dq_oe); end
    checks++; if (rwds_out !== 1'b0) begin errors++; $display("FAIL rst_rwds got %b exp 0", rwds_out); end
    checks++; if (rwds_oe !== 1'b0) begin errors++; $display("FAIL rst_rwds_oe got %b exp 0", rwds_oe); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    rst_n = 1'b1; clk_wait(12);
    checks++; if ({dq_out, dq_oe, rwds_out, rwds_oe} !== 11'h0) begin
      errors++; $display("FAIL idle_outputs got %h exp 000", {dq_out, dq_oe, rwds_out, rwds_oe});
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_err got %b exp 0", err); end
  endtask

  task automatic test_linear();
    logic [15:0] w;
    logic [1:0]  r;
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
    for (int i = 0; i < 4; i++) push_w(exp_w[i], 2'b00);
    do_write(48'h2000_0000_0004);
    open_cs();
    checks++; if ({rwds_oe, rwds_out} !== 2'b11) begin
      errors++; $display("FAIL lat_announce got %b exp 11", {rwds_oe, rwds_out});
    end
    send_ca(48'hA000_0000_0004);
    repeat (2 * LatCycles - 1) ck_cycle(8'h00, 8'h00, 1'b0, 1'b0);
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL lat_early_oe got %b exp 0", dq_oe); end
    ck_cycle(8'h00, 8'h00, 1'b0, 1'b0);
    checks++; if ({dq_oe, rwds_oe, rwds_out} !== 3'b110) begin
      errors++; $display("FAIL lat_done got %b exp 110", {dq_oe, rwds_oe, rwds_out});
    end
    for (int i = 0; i < 4; i++) begin
      rd_cycle(w, r);
      checks++; if (w !== exp_w[i]) begin errors++; $display("FAIL lin_rd%0d got %h exp %h", i, w, exp_w[i]); end
      checks++; if (r !== 2'b10) begin errors++; $display("FAIL lin_rwds%0d got %b exp 10", i, r); end
    end
    end_xfer();
    checks++; if ({dq_oe, rwds_oe} !== 2'b00) begin
      errors++; $display("FAIL lin_release got %b exp 00", {dq_oe, rwds_oe});
    end
  endtask

  task automatic test_wrap();
    int a;
    for (int i = 0; i < 6; i++) push_w(16'hA000 + 16'(i), 2'b00);
    do_write(make_ca(1'b0, 1'b0, 1'b1, NumWords - 4));
    push_w(16'hE00E, 2'b00); push_w(16'hF00F, 2'b00);
    do_write(make_ca(1'b0, 1'b0, 1'b1, 14));
    do_read(make_ca(1'b1, 1'b0, 1'b0, 14), 4);
    a = 14;
    foreach (rd_q[i]) begin
      checks++; if (rd_q[i] !== mdl[a]) begin errors++; $display("FAIL wrap_rd%0d got %h exp %h", i, rd_q[i], mdl[a]); end
      a = model_next(a, 1'b0);
    end
    do_read(make_ca(1'b1, 1'b0, 1'b1, NumWords - 1), 2);
    checks++; if (rd_q[0] !== mdl[NumWords-1]) begin errors++; $display("FAIL top_rd got %h exp %h", rd_q[0], mdl[NumWords-1]); end
    checks++; if (rd_q[1] !== mdl[0]) begin errors++; $display("FAIL top_wrap_rd got %h exp %h", rd_q[1], mdl[0]); end
  endtask

  task automatic test_masked();
    push_w(16'h0000, 2'b00);
    do_write(make_ca(1'b0, 1'b0, 1'b1, 8));
    push_w(16'hABCD, 2'b10);
    do_write(make_ca(1'b0, 1'b0, 1'b1, 8));
    do_read(make_ca(1'b1, 1'b0, 1'b1, 8), 1);
    checks++; if (rd_q[0] !== 16'h00CD) begin errors++; $display("FAIL masked_rd got %h exp 00cd", rd_q[0]); end
  endtask

  task automatic test_register();
    logic [47:0] ca;
    do_read(make_ca(1'b1, 1'b1, 1'b1, 0), 2);
    foreach (rd_q[i]) begin
      checks++; if (rd_q[i] !== IdValue) begin errors++; $display("FAIL reg_rd%0d got %h exp %h", i, rd_q[i], IdValue); end
    end
    ca = make_ca(1'b0, 1'b1, 1'b1, 4);
    open_cs(); send_ca(ca);
    ck_cycle(8'hDE, 8'hAD, 1'b0, 1'b0);
    clk_wait(6);
    checks++; if ({dq_oe, rwds_oe} !== 2'b00) begin
      errors++; $display("FAIL regwr_idle got %b exp 00", {dq_oe, rwds_oe});
    end
    end_xfer();
    do_read(make_ca(1'b1, 1'b0, 1'b1, 4), 1);
    checks++; if (rd_q[0] !== mdl[4]) begin errors++; $display("FAIL regwr_array got %h exp %h", rd_q[0], mdl[4]); end
  endtask

  task automatic test_abort();
    logic [47:0] ca;
    logic [15:0] w;
    logic [1:0]  r;
    ca = make_ca(1'b0, 1'b0, 1'b1, 40);
    open_cs();
    ck_cycle(ca[47:40], ca[39:32], 1'b0, 1'b0);
    dq_in = ca[31:24]; clk_wait(3); ck = 1'b1; clk_wait(3);
    cs_n = 1'b1; clk_wait(6);
    checks++; if ({dq_oe, rwds_oe} !== 2'b00) begin
      errors++; $display("FAIL abort_oe got %b exp 00", {dq_oe, rwds_oe});
    end
    checks++; if (err !== ErrEn) begin errors++; $display("FAIL abort_err got %b exp %b", err, ErrEn); end
    ck = 1'b0; clk_wait(30);
    checks++; if (err !== ErrEn) begin errors++; $display("FAIL err_sticky got %b exp %b", err, ErrEn); end
    push_w(16'h5A5A, 2'b00); push_w(16'hC3C3, 2'b00);
    do_write(ca);
    do_read(make_ca(1'b1, 1'b0, 1'b1, 40), 2);
    checks++; if (rd_q[0] !== 16'h5A5A) begin errors++; $display("FAIL post_abort0 got %h exp 5a5a", rd_q[0]); end
    checks++; if (rd_q[1] !== 16'hC3C3) begin errors++; $display("FAIL post_abort1 got %h exp c3c3", rd_q[1]); end
    // Partial word at the end of a write burst must be dropped.
    push_w(16'h0000, 2'b00); push_w(16'hBEEF, 2'b00);
    do_write(make_ca(1'b0, 1'b0, 1'b1, 30));
    open_cs(); send_ca(make_ca(1'b0, 1'b0, 1'b1, 30)); lat_phase();
    ck_cycle(8'h12, 8'h34, 1'b0, 1'b0);
    mdl[30] = 16'h1234;
    dq_in = 8'h56; clk_wait(3); ck = 1'b1; clk_wait(3);
    cs_n = 1'b1; clk_wait(6); ck = 1'b0; clk_wait(6);
    do_read(make_ca(1'b1, 1'b0, 1'b1, 30), 2);
    checks++; if (rd_q[0] !== mdl[30]) begin errors++; $display("FAIL part_full got %h exp %h", rd_q[0], mdl[30]); end
    checks++; if (rd_q[1] !== mdl[31]) begin errors++; $display("FAIL part_drop got %h exp %h", rd_q[1], mdl[31]); end
    // Device reset pin mid-read releases the bus.
    open_cs(); send_ca(make_ca(1'b1, 1'b0, 1'b1, 40)); lat_phase();
    rd_cycle(w, r);
    checks++; if (dq_oe !== 1'b1) begin errors++; $display("FAIL hrst_pre_oe got %b exp 1", dq_oe); end
    hrst_n = 1'b0; clk_wait(6);
    checks++; if ({dq_oe, rwds_oe} !== 2'b00) begin
      errors++; $display("FAIL hrst_oe got %b exp 00", {dq_oe, rwds_oe});
    end
    hrst_n = 1'b1; end_xfer();
  endtask

  task automatic test_random();
    int          a, a2, n;
    logic        lin;
    logic [1:0]  m;
    logic [15:0] km;
    for (int it = 0; it < 10; it++) begin
      a   = int'($urandom_range(0, NumWords - 1));
      n   = int'($urandom_range(1, 6));
      lin = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        push_w(16'($urandom), m);
      end
      do_write(make_ca(1'b0, 1'b0, lin, a));
      do_read(make_ca(1'b1, 1'b0, lin, a), n);
      a2 = a;
      foreach (rd_q[i]) begin
        km = {{8{known[a2][1]}}, {8{known[a2][0]}}};
        checks++; if ((rd_q[i] & km) !== (mdl[a2] & km)) begin
          errors++; $display("FAIL rand%0d_w%0d addr %0d got %h exp %h", it, i, a2, rd_q[i] & km, mdl[a2] & km);
        end
        checks++; if (rwp_q[i] !== 2'b10) begin errors++; $display("FAIL rand%0d_rwds%0d got %b exp 10", it, i, rwp_q[i]); end
        a2 = model_next(a2, lin);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] w;
    logic [1:0]  r;
    open_cs(); send_ca(make_ca(1'b1, 1'b0, 1'b1, 40)); lat_phase();
    rd_cycle(w, r);
    rst_n = 1'b0; #1;
    checks++; if ({dq_out, dq_oe, rwds_out, rwds_oe, err} !== 12'h0) begin
      errors++; $display("FAIL async_rst got %h exp 000", {dq_out, dq_oe, rwds_out, rwds_oe, err});
    end
    cs_n = 1'b1; clk_wait(4); rst_n = 1'b1; clk_wait(8);
    do_read(make_ca(1'b1, 1'b1, 1'b1, 0), 1);
    checks++; if (rd_q[0] !== IdValue) begin errors++; $display("FAIL post_rst_reg got %h exp %h", rd_q[0], IdValue); end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_wrap();
    test_masked();
    test_register();
    test_abort();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
